tpu_tile_sequencer: RTL and testbench
=====================================

Name: tpu_tile_sequencer

Overview:
- Central run controller for the TPU datapath: unified buffer, weight SRAM, systolic array and results SRAM.
- After a start pulse it processes a programmable number of MATRIX_SIZE-row tiles. For each tile it selects and reloads a weight set, streams activation rows from the unified buffer, waits out the array/skew pipeline, then writes result rows to the results SRAM.
- Replaces free-running counters with one FSM that owns every datapath strobe and address.

Parameters:
- ADDRESSSIZE, 10, width of unified-buffer and results-SRAM addresses.
- MATRIX_SIZE, 32, rows streamed and result rows written per tile.
- RESULT_LAT, 66, idle cycles between last streamed row and first result write (array plus input/output skew).
- WADDR_BW, 2, weight SRAM address width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  run request; sampled only in IDLE.
- num_tiles  in  4  tiles to process, 0..15; latched on accepted start.
- ub_base  in  ADDRESSSIZE  first unified-buffer row; latched on start.
- res_base  in  ADDRESSSIZE  first results-SRAM row; latched on start.
- w_base  in  WADDR_BW  weight set for tile 0; latched on start.
- busy  out  1  high while a run is in progress.
- done  out  1  one-cycle pulse at run completion.
- w_addr  out  WADDR_BW  weight SRAM address.
- we_rl  out  1  one-cycle weight-reload strobe to the systolic array.
- ub_rd_en  out  1  activation row valid / UB read strobe.
- ub_addr  out  ADDRESSSIZE  unified-buffer read address.
- res_we  out  1  results-SRAM write enable.
- res_addr  out  ADDRESSSIZE  results-SRAM write address.

Behaviour:
- Reset (any state, mid-run included): state IDLE; all outputs 0; tile and row counters 0. The run is abandoned; no done pulse.
- States: IDLE, LOAD_W, STREAM, DRAIN, WRITE, DONE. All outputs are registered.
- IDLE:
  - start=1 latches num_tiles, ub_base, res_base and w_base, and clears tile index t.
  - Goes to LOAD_W if num_tiles!=0, else to DONE.
  - start in any other state is ignored; it is not queued.
- LOAD_W (2 cycles):
  - Cycle 1: w_addr = w_base + t (mod 2^WADDR_BW); we_rl = 0.
  - Cycle 2: w_addr is held and we_rl = 1.
  - Then STREAM.
- STREAM (MATRIX_SIZE cycles, k = 0..MATRIX_SIZE-1):
  - ub_rd_en = 1.
  - ub_addr = ub_base + t*MATRIX_SIZE + k, mod 2^ADDRESSSIZE (wraps silently).
  - Then DRAIN.
- DRAIN (RESULT_LAT cycles): ub_rd_en, res_we and we_rl all 0. Then WRITE.
- WRITE (MATRIX_SIZE cycles):
  - res_we = 1.
  - res_addr = res_base + t*MATRIX_SIZE + k, mod 2^ADDRESSSIZE.
  - At the end, t increments; go to LOAD_W if t < num_tiles, else DONE.
- DONE (1 cycle): done = 1, then IDLE.
- busy:
  - 1 from the cycle after start is accepted through the DONE cycle inclusive.
  - Also 1 during the DONE cycle of a num_tiles=0 run.
  - 0 in IDLE.
- Strobes are 0 outside their own states. Addresses hold their last value when their strobe is low; only strobe-qualified values are checked.
- Timing: start sampled at cycle 0 gives tile period P = 2 + 2*MATRIX_SIZE + RESULT_LAT (132 at defaults), and done at cycle 1 + P*num_tiles.
- Counters are sized for MATRIX_SIZE and RESULT_LAT up to 255. Tile offset arithmetic is done at ADDRESSSIZE width with truncation.

Test Plan:
- Single tile: rst released, start with num_tiles=1, ub_base=0x010, res_base=0x100, w_base=0.
  - we_rl at cycle 2 only, with w_addr=0.
  - ub_rd_en cycles 3–34 with ub_addr 0x010..0x02F.
  - res_we cycles 101–132 with res_addr 0x100..0x11F.
  - done at cycle 133; busy cycles 1–133.
- Multi-tile with weight wrap: num_tiles=2, w_base=3.
  - Tile 0: w_addr=3, we_rl at cycle 2.
  - Tile 1: w_addr=0, we_rl at cycle 134.
  - Tile 1 ub_addr starts at ub_base+32 at cycle 135.
  - done at cycle 265.
- Address wrap: ub_base=0x3F0, num_tiles=1 -> ub_addr 0x3F0..0x3FF then 0x000..0x00F with no gap; res_base=0x3FF -> res_addr 0x3FF, 0x000..0x01E.
- Zero tiles and ignored start: num_tiles=0 -> done and busy at cycle 1 only, no strobes. A start pulse at cycle 50 of a running 1-tile job has no effect: done once at 133, nothing after.
- Mid-run reset: rst asserted at cycle 40 (DRAIN).
  - The following cycle: all outputs 0 and no done.
  - A new start after release runs a full 1-tile job with the exact timing of the single-tile scenario.
- Back-to-back runs: start held high continuously.
  - Second run accepted in the IDLE cycle after done (cycle 134).
  - Its we_rl at cycle 136; all outputs otherwise match the first run shifted by 134 cycles.

Source files
------------

// File: rtl/tpu_tile_sequencer.sv
// Run controller for the TPU datapath: per tile it reloads a weight set, streams
// activation rows, waits out the array pipeline, then writes the result rows.
module tpu_tile_sequencer #(
    parameter int ADDRESSSIZE = 10,
    parameter int MATRIX_SIZE = 32,
    parameter int RESULT_LAT  = 66,
    parameter int WADDR_BW    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             num_tiles,
    input  logic [ADDRESSSIZE-1:0] ub_base,
    input  logic [ADDRESSSIZE-1:0] res_base,
    input  logic [WADDR_BW-1:0]    w_base,
    output logic                   busy,
    output logic                   done,
    output logic [WADDR_BW-1:0]    w_addr,
    output logic                   we_rl,
    output logic                   ub_rd_en,
    output logic [ADDRESSSIZE-1:0] ub_addr,
    output logic                   res_we,
    output logic [ADDRESSSIZE-1:0] res_addr
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        STREAM,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam logic [7:0] ROWS_LAST  = 8'(MATRIX_SIZE - 1);
    localparam logic [7:0] DRAIN_LAST = 8'(RESULT_LAT - 1);

    state_t                 state_q, state_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [3:0]             tile_q, tile_d;
    logic [3:0]             ntiles_q, ntiles_d;
    logic [ADDRESSSIZE-1:0] ub_base_q, ub_base_d;
    logic [ADDRESSSIZE-1:0] res_base_q, res_base_d;
    logic [WADDR_BW-1:0]    w_base_q, w_base_d;
    logic [3:0]             tile_inc;

    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   we_rl_q, we_rl_d;
    logic                   ub_rd_en_q, ub_rd_en_d;
    logic                   res_we_q, res_we_d;
    logic [WADDR_BW-1:0]    w_addr_q, w_addr_d;
    logic [ADDRESSSIZE-1:0] ub_addr_q, ub_addr_d;
    logic [ADDRESSSIZE-1:0] res_addr_q, res_addr_d;
    logic [ADDRESSSIZE-1:0] row_off;

    assign tile_inc = tile_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tile_d     = tile_q;
        ntiles_d   = ntiles_q;
        ub_base_d  = ub_base_q;
        res_base_d = res_base_q;
        w_base_d   = w_base_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    ntiles_d   = num_tiles;
                    ub_base_d  = ub_base;
                    res_base_d = res_base;
                    w_base_d   = w_base;
                    tile_d     = 4'd0;
                    cnt_d      = 8'd0;
                    state_d    = (num_tiles != 4'd0) ? LOAD_W : DONE;
                end
            end
            LOAD_W: begin
                if (cnt_q == 8'd1) begin
                    cnt_d   = 8'd0;
                    state_d = STREAM;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            STREAM: begin
                if (cnt_q == ROWS_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = DRAIN;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = WRITE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            WRITE: begin
                if (cnt_q == ROWS_LAST) begin
                    cnt_d   = 8'd0;
                    tile_d  = tile_inc;
                    state_d = (tile_inc < ntiles_q) ? LOAD_W : DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        row_off    = ADDRESSSIZE'(32'(tile_d) * 32'(MATRIX_SIZE)) + ADDRESSSIZE'(cnt_d);
        busy_d     = (state_d != IDLE);
        done_d     = (state_d == DONE);
        we_rl_d    = (state_d == LOAD_W) && (cnt_d == 8'd1);
        ub_rd_en_d = (state_d == STREAM);
        res_we_d   = (state_d == WRITE);
        w_addr_d   = (state_d == LOAD_W) ? (w_base_d + WADDR_BW'(tile_d)) : w_addr_q;
        ub_addr_d  = (state_d == STREAM) ? (ub_base_d + row_off) : ub_addr_q;
        res_addr_d = (state_d == WRITE) ? (res_base_d + row_off) : res_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            tile_q     <= 4'd0;
            ntiles_q   <= 4'd0;
            ub_base_q  <= '0;
            res_base_q <= '0;
            w_base_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            we_rl_q    <= 1'b0;
            ub_rd_en_q <= 1'b0;
            res_we_q   <= 1'b0;
            w_addr_q   <= '0;
            ub_addr_q  <= '0;
            res_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tile_q     <= tile_d;
            ntiles_q   <= ntiles_d;
            ub_base_q  <= ub_base_d;
            res_base_q <= res_base_d;
            w_base_q   <= w_base_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            we_rl_q    <= we_rl_d;
            ub_rd_en_q <= ub_rd_en_d;
            res_we_q   <= res_we_d;
            w_addr_q   <= w_addr_d;
            ub_addr_q  <= ub_addr_d;
            res_addr_q <= res_addr_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign we_rl    = we_rl_q;
    assign ub_rd_en = ub_rd_en_q;
    assign res_we   = res_we_q;
    assign w_addr   = w_addr_q;
    assign ub_addr  = ub_addr_q;
    assign res_addr = res_addr_q;

endmodule

// File: tb/tb_tpu_tile_sequencer.sv
// Directed bench for tpu_tile_sequencer: every expected strobe is queued with its
// cycle and address when a run is launched, and matched as the DUT emits it.
module tb_tpu_tile_sequencer;

    localparam int AW = 10;
    localparam int MS = 32;
    localparam int RL = 66;
    localparam int WB = 2;
    localparam int P  = 2 + 2 * MS + RL;

    localparam logic [3:0] K_NONE = 4'd0;
    localparam logic [3:0] K_WRL  = 4'd1;
    localparam logic [3:0] K_UB   = 4'd2;
    localparam logic [3:0] K_RES  = 4'd3;
    localparam logic [3:0] K_DONE = 4'd4;

    typedef struct packed {
        logic [31:0] cyc;
        logic [3:0]  kind;
        logic [15:0] addr;
    } ev_t;

    typedef struct {
        int lo;
        int hi;
    } win_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [3:0]    num_tiles;
    logic [AW-1:0] ub_base;
    logic [AW-1:0] res_base;
    logic [WB-1:0] w_base;
    logic          busy;
    logic          done;
    logic [WB-1:0] w_addr;
    logic          we_rl;
    logic          ub_rd_en;
    logic [AW-1:0] ub_addr;
    logic          res_we;
    logic [AW-1:0] res_addr;
    logic [26:0]   outs;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;
    ev_t  sb[$];
    win_t bw[$];

    tpu_tile_sequencer #(
        .ADDRESSSIZE(AW),
        .MATRIX_SIZE(MS),
        .RESULT_LAT (RL),
        .WADDR_BW   (WB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_tiles(num_tiles),
        .ub_base  (ub_base),
        .res_base (res_base),
        .w_base   (w_base),
        .busy     (busy),
        .done     (done),
        .w_addr   (w_addr),
        .we_rl    (we_rl),
        .ub_rd_en (ub_rd_en),
        .ub_addr  (ub_addr),
        .res_we   (res_we),
        .res_addr (res_addr)
    );

    assign outs = {busy, done, we_rl, ub_rd_en, res_we, w_addr, ub_addr, res_addr};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected strobes of one run whose start is high during cycle t0.
    task automatic push_run(input int t0, input int nt, input int ub, input int rs, input int wb);
        ev_t e;
        win_t w;
        int base;
        for (int t = 0; t < nt; t++) begin
            base = t0 + 1 + P * t;
            e = '{cyc: 32'(base + 1), kind: K_WRL, addr: 16'((wb + t) % (1 << WB))};
            sb.push_back(e);
            for (int k = 0; k < MS; k++) begin
                e = '{cyc: 32'(base + 2 + k), kind: K_UB, addr: 16'((ub + t * MS + k) % (1 << AW))};
                sb.push_back(e);
            end
            for (int k = 0; k < MS; k++) begin
                e = '{cyc: 32'(base + 2 + MS + RL + k), kind: K_RES,
                      addr: 16'((rs + t * MS + k) % (1 << AW))};
                sb.push_back(e);
            end
        end
        e = '{cyc: 32'(t0 + 1 + P * nt), kind: K_DONE, addr: 16'd0};
        sb.push_back(e);
        w.lo = t0 + 1;
        w.hi = t0 + 1 + P * nt;
        bw.push_back(w);
    endtask

    task automatic check_ev(input ev_t obs);
        ev_t exp;
        if (sb.size() == 0) exp = '{cyc: obs.cyc, kind: K_NONE, addr: 16'd0};
        else exp = sb.pop_front();
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL event: got cyc=%0d kind=%0d addr=0x%0h, want cyc=%0d kind=%0d addr=0x%0h",
                   obs.cyc, obs.kind, obs.addr, exp.cyc, exp.kind, exp.addr);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            logic exp_busy;
            while (sb.size() > 0 && int'(sb[0].cyc) < cyc)
                check_ev('{cyc: sb[0].cyc, kind: K_NONE, addr: 16'd0});
            if (we_rl)    check_ev('{cyc: 32'(cyc), kind: K_WRL,  addr: 16'(w_addr)});
            if (ub_rd_en) check_ev('{cyc: 32'(cyc), kind: K_UB,   addr: 16'(ub_addr)});
            if (res_we)   check_ev('{cyc: 32'(cyc), kind: K_RES,  addr: 16'(res_addr)});
            if (done)     check_ev('{cyc: 32'(cyc), kind: K_DONE, addr: 16'd0});
            exp_busy = 1'b0;
            foreach (bw[i]) if (cyc >= bw[i].lo && cyc <= bw[i].hi) exp_busy = 1'b1;
            n_cmp++;
            assert (busy === exp_busy)
            else begin
                n_err++;
                $error("FAIL busy@%0d: got %b want %b", cyc, busy, exp_busy);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic launch(input int nt, input int ub, input int rs, input int wb, output int t0);
        num_tiles = 4'(nt);
        ub_base   = AW'(ub);
        res_base  = AW'(rs);
        w_base    = WB'(wb);
        start     = 1'b1;
        t0        = cyc;
        push_run(t0, nt, ub, rs, wb);
        tick();
        start = 1'b0;
    endtask

    task automatic check_drained(input string tag);
        n_cmp++;
        assert (sb.size() === 0)
        else begin
            n_err++;
            $error("FAIL %s: %0d expected events left, want 0", tag, sb.size());
        end
    endtask

    task automatic check_zero(input string tag);
        n_cmp++;
        assert (outs === 27'd0)
        else begin
            n_err++;
            $error("FAIL %s: outputs 0x%0h want 0x0", tag, outs);
        end
    endtask

    initial begin
        int t0;
        rst = 1'b1; start = 1'b0; num_tiles = 4'd0;
        ub_base = '0; res_base = '0; w_base = '0;
        repeat (3) tick();
        check_zero("reset_state");
        rst = 1'b0;
        tick();
        mon_en = 1'b1;

        // Single tile, with a stray start mid-run that must be ignored.
        launch(1, 'h010, 'h100, 0, t0);
        wait_until(t0 + 50);
        num_tiles = 4'd3; ub_base = AW'('h2AA); start = 1'b1;
        tick();
        start = 1'b0;
        wait_until(t0 + 145);
        check_drained("single_tile");

        // Two tiles, weight address wraps 3 -> 0.
        launch(2, 'h040, 'h200, 3, t0);
        wait_until(t0 + 2 * P + 10);
        check_drained("multi_tile");

        // Address wrap on both UB and results.
        launch(1, 'h3F0, 'h3FF, 1, t0);
        wait_until(t0 + P + 10);
        check_drained("addr_wrap");

        // Zero tiles: done and busy for one cycle only.
        launch(0, 'h123, 'h321, 2, t0);
        wait_until(t0 + 10);
        check_drained("zero_tiles");

        // Reset during DRAIN abandons the run.
        launch(1, 'h080, 'h180, 2, t0);
        wait_until(t0 + 40);
        rst = 1'b1;
        sb.delete();
        bw.delete();
        tick();
        check_zero("midrun_reset");
        rst = 1'b0;
        tick();
        launch(1, 'h010, 'h100, 0, t0);
        wait_until(t0 + P + 10);
        check_drained("after_reset");

        // Start held high: second run accepted in the IDLE cycle after done.
        num_tiles = 4'd1; ub_base = AW'('h050); res_base = AW'('h150); w_base = WB'(1);
        start = 1'b1;
        t0 = cyc;
        push_run(t0, 1, 'h050, 'h150, 1);
        push_run(t0 + P + 2, 1, 'h050, 'h150, 1);
        wait_until(t0 + P + 3);
        start = 1'b0;
        wait_until(t0 + 2 * P + 15);
        check_drained("back_to_back");

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
